// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with double-buffered display value.
// Ports: clk, reset (async, active-high); value/load capture a new display value,
//   applied at the next frame boundary; dp_mask/digit_en act live per digit;
//   seg {g,f,e,d,c,b,a}, dp, digit_sel (one-hot strobe) and frame_tick are registered.
// Optional: define SSD_LZ_SUPPRESS_EN to blank leading zero digits.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int SEG_ACT_LOW  = 1,
    parameter int DIG_ACT_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);

    typedef enum logic {BLANK, SHOW} state_t;

    localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic          DP_OFF     = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;
    localparam state_t        RST_STATE  = (BLANK_CYCLES > 0) ? BLANK : SHOW;
    localparam state_t        AFTER_SHOW = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] staging, disp;
    logic                    pending;

    logic [3:0]              nib;
    logic                    cur_dp, cur_en, lz_blank;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [6:0]              raw, seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   sel_n;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Slot sequencer: cnt counts cycles inside the current phase.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        wrap    = 1'b0;
        unique case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_n = AFTER_SHOW;
                    cnt_n   = '0;
                    wrap    = (idx == IDX_LAST);
                    idx_n   = wrap ? '0 : idx + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RST_STATE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // Per-digit mux; a loop avoids indexing past NUM_DIGITS for odd sizes.
    always_comb begin
        nib    = 4'h0;
        cur_dp = 1'b0;
        cur_en = 1'b0;
        onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) begin
                nib       = disp[4*i +: 4];
                cur_dp    = dp_mask[i];
                cur_en    = digit_en[i];
                onehot[i] = 1'b1;
            end
        end
    end

`ifdef SSD_LZ_SUPPRESS_EN
    // Digit i is a leading zero when nibbles i..top are all zero.
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        lz_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero && (disp[4*i +: 4] == 4'h0);
            if (IW'(i) == idx)
                lz_blank = run_zero && (i != 0);
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        raw   = lz_blank ? 7'h00 : hex7(nib);
        seg_n = SEG_OFF;
        dp_n  = DP_OFF;
        sel_n = DIG_OFF;
        if (state == SHOW && cur_en) begin
            seg_n = (SEG_ACT_LOW != 0) ? ~raw : raw;
            dp_n  = (SEG_ACT_LOW != 0) ? ~cur_dp : cur_dp;
            sel_n = (DIG_ACT_LOW != 0) ? ~onehot : onehot;
        end
    end

    // Display buffer swaps only on the wrap cycle so a frame never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging    <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            digit_sel  <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_n;
            dp         <= dp_n;
            digit_sel  <= sel_n;
            frame_tick <= wrap;
            if (load)
                staging <= value;
            if (wrap) begin
                pending <= 1'b0;
                if (load)
                    disp <= value;
                else if (pending)
                    disp <= staging;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: 4 digits, 3-cycle dwell, 1-cycle blank,
// active-low segments and strobes.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    int compared = 0;
    int mismatched = 0;

    localparam logic [6:0] S_OFF = 7'h7F;
    localparam logic [6:0] S_0 = 7'h40;
    localparam logic [6:0] S_1 = 7'h79;
    localparam logic [6:0] S_2 = 7'h24;
    localparam logic [6:0] S_3 = 7'h30;
    localparam logic [6:0] S_5 = 7'h12;
    localparam logic [6:0] S_A = 7'h08;
    localparam logic [6:0] S_F = 7'h0E;
`ifdef SSD_LZ_SUPPRESS_EN
    localparam logic [6:0] S_LZ = S_OFF;
`else
    localparam logic [6:0] S_LZ = S_0;
`endif

    ssd_scan_ctrl #(
        .NUM_DIGITS(4),
        .SCAN_DIV(3),
        .BLANK_CYCLES(1),
        .SEG_ACT_LOW(1),
        .DIG_ACT_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .load(load),
        .dp_mask(dp_mask),
        .digit_en(digit_en),
        .seg(seg),
        .dp(dp),
        .digit_sel(digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".seg"}, 16'(seg), 16'h7F);
        chk({tag, ".dp"}, 16'(dp), 16'h1);
        chk({tag, ".sel"}, 16'(digit_sel), 16'hF);
        chk({tag, ".tick"}, 16'(frame_tick), 16'h0);
    endtask

    // Walks one 16-cycle frame starting right after a frame start edge,
    // sampling on negedges. Slot layout: 1 blank + 3 lit cycles per digit.
    task automatic run_frame(input string tag, input logic [27:0] exp_seg,
                             input int stop_at,
                             input int la1, input logic [15:0] v1,
                             input int la2, input logic [15:0] v2);
        for (int c = 1; c <= 16; c++) begin
            int d;
            logic [6:0] es;
            logic       ed;
            logic [3:0] el;
            @(negedge clk);
            d  = (c - 1) / 4;
            es = S_OFF;
            ed = 1'b1;
            el = 4'hF;
            if ((c - 1) % 4 != 0 && digit_en[d]) begin
                es = exp_seg[7*d +: 7];
                ed = ~dp_mask[d];
                el = ~(4'b0001 << d);
            end
            chk($sformatf("%s.c%0d.seg", tag, c), 16'(seg), 16'(es));
            chk($sformatf("%s.c%0d.dp", tag, c), 16'(dp), 16'(ed));
            chk($sformatf("%s.c%0d.sel", tag, c), 16'(digit_sel), 16'(el));
            chk($sformatf("%s.c%0d.tick", tag, c), 16'(frame_tick),
                16'(c == 16));
            if (c == stop_at) begin
                load = 1'b0;
                return;
            end
            if (c == la1) begin
                value = v1;
                load = 1'b1;
            end else if (c == la2) begin
                value = v2;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 chk_reset_outs("rst_async");
        repeat (2) @(negedge clk);
        chk_reset_outs("rst_held");
        reset = 1'b0;

        // Load mid-frame: display must stay at reset value this frame.
        run_frame("f0", {S_0, S_0, S_0, S_0}, 0, 5, 16'h12AF, 0, 16'h0);
        dp_mask = 4'b0101;
        // New value now visible; two loads, last must win next frame.
        run_frame("f1", {S_1, S_2, S_A, S_F}, 0, 3, 16'h1111, 8, 16'h2222);
        // Load on the boundary cycle applies without a frame of delay.
        run_frame("f2", {S_2, S_2, S_2, S_2}, 0, 15, 16'h3333, 0, 16'h0);
        run_frame("f3", {S_3, S_3, S_3, S_3}, 0, 4, 16'h0050, 0, 16'h0);
        digit_en = 4'b1011;
        run_frame("f4", {S_LZ, S_LZ, S_5, S_0}, 0, 0, 16'h0, 0, 16'h0);

        // Reset during digit 2's slot with a load still pending.
        run_frame("f5", {S_LZ, S_LZ, S_5, S_0}, 11, 2, 16'h9999, 0, 16'h0);
        reset = 1'b1;
        #1 chk_reset_outs("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_frame("f6", {S_0, S_0, S_0, S_0}, 0, 0, 16'h0, 0, 16'h0);
        run_frame("f7", {S_0, S_0, S_0, S_0}, 0, 0, 16'h0, 0, 16'h0);

        // Async reset while a digit is lit.
        digit_en = 4'hF;
        run_frame("f8", {S_0, S_0, S_0, S_0}, 3, 0, 16'h0, 0, 16'h0);
        reset = 1'b1;
        #1 chk_reset_outs("rst_lit");
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
